// File: rtl/mem_bus_pkg.sv
// Shared command encodings, FSM state type and index-width helper for mem_bus_ctrl.
package mem_bus_pkg;

    localparam logic [1:0] M_NOP   = 2'b00;
    localparam logic [1:0] M_READ  = 2'b10;
    localparam logic [1:0] M_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } bus_state_t;

    // Width of the I/O register index; never below one bit.
    function automatic int io_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_io_regs.sv
// Bank of NUM_IO I/O registers: indexed write port, indexed read mux of the
// external input words, and out-of-range index detect.
module mem_io_regs
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_IO = 2,
    localparam int IO_IW = io_idx_w(NUM_IO)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [IO_IW-1:0]         i_idx,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [NUM_IO*DATA_W-1:0] i_io_in,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_oor,
    output logic [NUM_IO*DATA_W-1:0] o_io_out
);

    logic [NUM_IO*DATA_W-1:0] r_regs;
    int                       w_idx;

    assign w_idx    = int'(i_idx);
    assign o_oor    = (w_idx >= NUM_IO);
    assign o_io_out = r_regs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_regs <= '0;
        end else if (i_we && !o_oor) begin
            for (int k = 0; k < NUM_IO; k++) begin
                if (w_idx == k) begin
                    r_regs[k*DATA_W +: DATA_W] <= i_wdata;
                end
            end
        end
    end

    // Out-of-range index matches no word, so the read falls through to zero.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (w_idx == k) begin
                o_rdata = i_io_in[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-RAM/I-O bus controller with registered handshake and programmable wait states.
// Optional bus error reporting (bus_err, err_flag) is enabled by defining MEM_BUS_ERR_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int RAM_AW      = 8,
    parameter int WAIT_STATES = 1,
    parameter int NUM_IO      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mem_cmd,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     mem_ready,
    output logic [RAM_AW-1:0]        ram_addr,
    output logic                     ram_write,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
`ifdef MEM_BUS_ERR_EN
    output logic                     bus_err,
    output logic                     err_flag,
`endif
    input  logic [NUM_IO*DATA_W-1:0] io_in,
    output logic [NUM_IO*DATA_W-1:0] io_out
);

    localparam int         IO_IW    = io_idx_w(NUM_IO);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    bus_state_t          r_state;
    bus_state_t          w_next_state;
    logic [1:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_accept;
    logic                w_access;
    logic                w_is_io;
    logic                w_is_read;
    logic                w_is_write;
    logic                w_io_we;
    logic                w_io_oor;
    logic [IO_IW-1:0]    w_idx;
    logic [DATA_W-1:0]   w_io_rdata;

    assign w_accept   = (r_state == IDLE) && ((mem_cmd == M_READ) || (mem_cmd == M_WRITE));
    assign w_access   = (r_state == WAIT) && (r_cnt <= 4'd1);
    assign w_is_io    = r_addr[ADDR_W-1];
    assign w_is_read  = (r_cmd == M_READ);
    assign w_is_write = (r_cmd == M_WRITE);
    assign w_idx      = r_addr[IO_IW-1:0];
    assign w_io_we    = w_access && w_is_io && w_is_write && !w_io_oor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = WAIT;
            WAIT:    if (r_cnt <= 4'd1) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (r_state == DONE);
        ram_write = (r_state == DONE) && !w_is_io && w_is_write;
    end

    // Request fields are captured only on acceptance, so CPU-side changes later are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd   <= M_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cmd   <= mem_cmd;
                r_addr  <= mem_addr;
                r_wdata <= cpu_wdata;
                r_cnt   <= WAIT_CNT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && w_is_read) begin
                r_rdata <= w_is_io ? w_io_rdata : ram_rdata;
            end
        end
    end

    assign cpu_rdata = r_rdata;
    assign ram_addr  = r_addr[RAM_AW-1:0];
    assign ram_wdata = r_wdata;

    mem_io_regs #(
        .DATA_W (DATA_W),
        .NUM_IO (NUM_IO)
    ) u_io_regs (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_we     (w_io_we),
        .i_idx    (w_idx),
        .i_wdata  (r_wdata),
        .i_io_in  (io_in),
        .o_rdata  (w_io_rdata),
        .o_oor    (w_io_oor),
        .o_io_out (io_out)
    );

`ifdef MEM_BUS_ERR_EN
    logic r_err_flag;

    assign bus_err  = (r_state == DONE) && w_is_io && w_io_oor;
    assign err_flag = r_err_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_flag <= 1'b0;
        end else if (bus_err) begin
            r_err_flag <= 1'b1;
        end
    end
`endif

endmodule
